adc_sample_uart_tx: RTL and testbench

Consumes 8-bit samples from the ADC demo's successive-approximation core and streams each one over the board's UART `tx` pin as human-readable hex text. Each sample becomes two uppercase hex digits followed by CR LF. The block sits directly downstream of the ADC sample register and drives the top-level `tx` output, replacing the idle-high tie-off. The ADC side uses a valid/ready handshake so no sample is lost or torn mid-frame.

---
 rtl/adc_demo_pkg.sv | 27 ++
 rtl/uart_tx_byte.sv | 127 ++++++++++++
 rtl/adc_sample_uart_tx.sv | 85 ++++++++
 tb/tb_adc_sample_uart_tx.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/adc_demo_pkg.sv
// -----------------------------------------------------------------------------
// adc_demo_pkg : shared types, ASCII constants and hex helper for the ADC demo
// Rev 1.0
// -----------------------------------------------------------------------------
`default_nettype none

package adc_demo_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } uart_state_t;

  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_LF = 8'h0A;

  // Uppercase hex digit: '0'..'9' then 'A'..'F' (0x41 - 10 = 0x37).
  function automatic logic [7:0] hex_ascii(input logic [3:0] n);
    if (n < 4'd10) return 8'h30 + {4'h0, n};
    else           return 8'h37 + {4'h0, n};
  endfunction

endpackage

`default_nettype wire

// File: rtl/uart_tx_byte.sv
// -----------------------------------------------------------------------------
// uart_tx_byte : 8N1 byte serialiser with registered tx and back-to-back start
// Rev 1.0
// -----------------------------------------------------------------------------
`default_nettype none

module uart_tx_byte
  import adc_demo_pkg::*;
#(
  parameter int CLKS_PER_BIT = 104
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] data,
  input  logic       start,
  output logic       tx,
  output logic       done
);

  localparam int BAUD_W = $clog2(CLKS_PER_BIT);

  uart_state_t       r_state;
  uart_state_t       w_state_next;
  logic [BAUD_W-1:0] r_baud;
  logic [BAUD_W-1:0] w_baud_next;
  logic [2:0]        r_bit;
  logic [2:0]        w_bit_next;
  logic [2:0]        w_bit_inc;
  logic [7:0]        r_data;
  logic [7:0]        w_data_next;
  logic              r_tx;
  logic              w_tx_next;
  logic              w_bit_end;
  logic              w_done;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_next;
  end

  // done fires in the last cycle of a stop bit so a new start can chain with no gap.
  always_comb begin
    w_state_next = r_state;
    w_baud_next  = r_baud;
    w_bit_next   = r_bit;
    w_data_next  = r_data;
    w_tx_next    = r_tx;
    w_done       = 1'b0;
    w_bit_end    = (r_baud == BAUD_W'(CLKS_PER_BIT - 1));
    w_bit_inc    = r_bit + 3'd1;
    case (r_state)
      ST_IDLE: begin
        w_baud_next = '0;
        w_tx_next   = 1'b1;
        if (start) begin
          w_data_next  = data;
          w_tx_next    = 1'b0;
          w_state_next = ST_START;
        end
      end
      ST_START: begin
        if (w_bit_end) begin
          w_baud_next  = '0;
          w_bit_next   = 3'd0;
          w_tx_next    = r_data[0];
          w_state_next = ST_DATA;
        end else begin
          w_baud_next = r_baud + BAUD_W'(1);
        end
      end
      ST_DATA: begin
        if (w_bit_end) begin
          w_baud_next = '0;
          w_bit_next  = w_bit_inc;
          if (r_bit == 3'd7) begin
            w_tx_next    = 1'b1;
            w_state_next = ST_STOP;
          end else begin
            w_tx_next = r_data[w_bit_inc];
          end
        end else begin
          w_baud_next = r_baud + BAUD_W'(1);
        end
      end
      ST_STOP: begin
        if (w_bit_end) begin
          w_baud_next = '0;
          w_done      = 1'b1;
          if (start) begin
            w_data_next  = data;
            w_tx_next    = 1'b0;
            w_state_next = ST_START;
          end else begin
            w_tx_next    = 1'b1;
            w_state_next = ST_IDLE;
          end
        end else begin
          w_baud_next = r_baud + BAUD_W'(1);
        end
      end
      default: begin
        w_tx_next    = 1'b1;
        w_state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_baud <= '0;
      r_bit  <= 3'd0;
      r_data <= 8'h00;
      r_tx   <= 1'b1;
    end else begin
      r_baud <= w_baud_next;
      r_bit  <= w_bit_next;
      r_data <= w_data_next;
      r_tx   <= w_tx_next;
    end
  end

  assign tx   = r_tx;
  assign done = w_done;

endmodule

`default_nettype wire

// File: rtl/adc_sample_uart_tx.sv
// -----------------------------------------------------------------------------
// adc_sample_uart_tx : streams each ADC sample as two hex digits plus CR LF
// Rev 1.0
// -----------------------------------------------------------------------------
`default_nettype none

module adc_sample_uart_tx
  import adc_demo_pkg::*;
#(
  parameter int CLK_HZ       = 12000000,
  parameter int BAUD         = 115200,
  parameter int CLKS_PER_BIT = CLK_HZ / BAUD
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] sample,
  input  logic       sample_valid,
  output logic       sample_ready,
  output logic       tx,
  output logic       busy
);

  logic       r_busy;
  logic [7:0] r_sample;
  logic [1:0] r_char_idx;
  logic       w_accept;
  logic       w_next_char;
  logic       w_start;
  logic       w_done;
  logic [1:0] w_sel;
  logic [7:0] w_src;
  logic [7:0] w_char;

  assign w_accept    = sample_valid && !r_busy;
  assign w_next_char = r_busy && w_done && (r_char_idx != 2'd3);
  assign w_start     = w_accept || w_next_char;

  // On accept the first digit comes straight from the input so tx can fall one edge later.
  always_comb begin
    w_src = r_busy ? r_sample : sample;
    w_sel = r_busy ? (r_char_idx + 2'd1) : 2'd0;
    case (w_sel)
      2'd0:    w_char = hex_ascii(w_src[7:4]);
      2'd1:    w_char = hex_ascii(w_src[3:0]);
      2'd2:    w_char = ASCII_CR;
      default: w_char = ASCII_LF;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy     <= 1'b0;
      r_sample   <= 8'h00;
      r_char_idx <= 2'd0;
    end else if (w_accept) begin
      r_busy     <= 1'b1;
      r_sample   <= sample;
      r_char_idx <= 2'd0;
    end else if (r_busy && w_done) begin
      if (r_char_idx == 2'd3) begin
        r_busy     <= 1'b0;
        r_char_idx <= 2'd0;
      end else begin
        r_char_idx <= r_char_idx + 2'd1;
      end
    end
  end

  uart_tx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_tx (
    .clk  (clk),
    .rst_n(rst_n),
    .data (w_char),
    .start(w_start),
    .tx   (tx),
    .done (w_done)
  );

  assign sample_ready = !r_busy;
  assign busy         = r_busy;

endmodule

`default_nettype wire

// File: tb/tb_adc_sample_uart_tx.sv
// -----------------------------------------------------------------------------
// tb_adc_sample_uart_tx : directed bench, 4-cycle bit instance plus default instance
// Rev 1.0
// -----------------------------------------------------------------------------
`default_nettype none

module tb_adc_sample_uart_tx;

  localparam int C  = 4;
  localparam int CD = 104;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] sample = 8'h00;
  logic       sample_valid = 1'b0;
  logic       sample_ready, tx, busy;
  logic [7:0] sample_d = 8'h00;
  logic       sample_valid_d = 1'b0;
  logic       sample_ready_d, tx_d, busy_d;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  adc_sample_uart_tx #(.CLK_HZ(460800), .BAUD(115200)) dut (
    .clk(clk), .rst_n(rst_n), .sample(sample), .sample_valid(sample_valid),
    .sample_ready(sample_ready), .tx(tx), .busy(busy)
  );

  adc_sample_uart_tx dut_def (
    .clk(clk), .rst_n(rst_n), .sample(sample_d), .sample_valid(sample_valid_d),
    .sample_ready(sample_ready_d), .tx(tx_d), .busy(busy_d)
  );

  typedef struct {
    logic [7:0]  s;
    logic [31:0] exp;
    string       name;
  } vec_t;

  vec_t vecs[5];

  task automatic check(input bit ok, input string name, input int act, input int exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Called on the falling edge that ends the handshake cycle.
  task automatic handshake(input bit def, input logic [7:0] s, input string name);
    @(negedge clk);
    check((def ? sample_ready_d : sample_ready) === 1'b1, {name, " ready before accept"},
          int'(def ? sample_ready_d : sample_ready), 1);
    if (def) begin sample_d = s; sample_valid_d = 1'b1; end
    else     begin sample   = s; sample_valid   = 1'b1; end
    @(negedge clk);
  endtask

  // Entered in cycle T+1; leaves in cycle T+40*cpb+1.
  task automatic check_frame(input bit def, input logic [31:0] exp, input logic [7:0] mid_s,
                             input logic mid_v, input string name);
    int cpb, j, pos, ci, wave_err, edge_err, hs_err, first_bad;
    logic [7:0] ch;
    logic [7:0] dec [4];
    logic cur, prev, expb;
    cpb = def ? CD : C;
    wave_err = 0; edge_err = 0; hs_err = 0; first_bad = -1;
    prev = 1'b1;
    for (int k = 1; k <= 40 * cpb; k++) begin
      if (k == 1) begin
        if (def) begin sample_d = mid_s; sample_valid_d = mid_v; end
        else     begin sample   = mid_s; sample_valid   = mid_v; end
      end
      j   = (k - 1) / cpb;
      pos = j % 10;
      ci  = j / 10;
      ch  = exp[31 - 8 * ci -: 8];
      expb = (pos == 0) ? 1'b0 : (pos == 9) ? 1'b1 : ch[pos - 1];
      cur = def ? tx_d : tx;
      if (cur !== expb) begin
        wave_err++;
        if (first_bad < 0) first_bad = k;
      end
      if (cur !== prev && ((k - 1) % cpb) != 0) edge_err++;
      prev = cur;
      if ((def ? busy_d : busy) !== 1'b1 || (def ? sample_ready_d : sample_ready) !== 1'b0)
        hs_err++;
      if (((k - 1) % cpb) == cpb / 2 && pos >= 1 && pos <= 8) dec[ci][pos - 1] = cur;
      @(negedge clk);
    end
    check(wave_err == 0, {name, " tx waveform bad cycles"}, wave_err, 0);
    check(edge_err == 0, {name, " tx edges off bit boundary"}, edge_err, 0);
    check(hs_err == 0, {name, " busy/ready during frame"}, hs_err, 0);
    for (int c = 0; c < 4; c++)
      check(dec[c] === exp[31 - 8 * c -: 8], $sformatf("%s char%0d", name, c),
            int'(dec[c]), int'(exp[31 - 8 * c -: 8]));
    if (def)
      check({sample_ready_d, busy_d, tx_d} === 3'b101, {name, " ready/busy/tx after frame"},
            int'({sample_ready_d, busy_d, tx_d}), 5);
    else
      check({sample_ready, busy, tx} === 3'b101, {name, " ready/busy/tx after frame"},
            int'({sample_ready, busy, tx}), 5);
  endtask

  initial begin
    int bad;
    vecs[0] = '{8'h3A, 32'h33410D0A, "s3A"};
    vecs[1] = '{8'h00, 32'h30300D0A, "s00"};
    vecs[2] = '{8'hFF, 32'h46460D0A, "sFF"};
    vecs[3] = '{8'h9F, 32'h39460D0A, "s9F"};
    vecs[4] = '{8'h5C, 32'h35430D0A, "s5C"};

    // Reset held 5 cycles, then 100 quiet cycles.
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if ({tx, sample_ready, busy, tx_d, sample_ready_d, busy_d} !== 6'b110110) bad++;
    end
    check(bad == 0, "reset outputs", bad, 0);
    rst_n = 1'b1;
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if ({tx, sample_ready, busy} !== 3'b110) bad++;
    end
    check(bad == 0, "idle after reset", bad, 0);

    for (int v = 0; v < 5; v++) begin
      handshake(1'b0, vecs[v].s, vecs[v].name);
      check_frame(1'b0, vecs[v].exp, 8'hEE, 1'b0, vecs[v].name);
    end

    // Valid held: second sample changes mid-frame, taken on the first ready cycle.
    handshake(1'b0, 8'h12, "held12");
    check_frame(1'b0, 32'h31320D0A, 8'h34, 1'b1, "held12");
    @(negedge clk);
    check(tx === 1'b0 && busy === 1'b1, "back-to-back start bit", int'({tx, busy}), 1);
    check_frame(1'b0, 32'h33340D0A, 8'h99, 1'b0, "held34");

    // Reset pulse during char1 data bit 3 of 0xA5 ('5' = 0x35, bit3 = 0).
    handshake(1'b0, 8'hA5, "rstA5");
    sample_valid = 1'b0;
    repeat (14 * C + 1) @(negedge clk);
    check(tx === 1'b0, "tx low at char1 bit3", int'(tx), 0);
    #2 rst_n = 1'b0;
    #1 check({tx, sample_ready, busy} === 3'b110, "async reset mid-frame",
             int'({tx, sample_ready, busy}), 6);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    bad = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if ({tx, sample_ready, busy} !== 3'b110) bad++;
    end
    check(bad == 0, "abandoned frame stays idle", bad, 0);
    handshake(1'b0, 8'h5A, "after_rst5A");
    check_frame(1'b0, 32'h35410D0A, 8'h00, 1'b0, "after_rst5A");

    // Default parameters: 104 cycles per bit, 4160-cycle frame.
    handshake(1'b1, 8'h7E, "def7E");
    check_frame(1'b1, 32'h37450D0A, 8'h00, 1'b0, "def7E");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
